// File: rtl/lzc_byte_feeder.sv
// Feeds one WIDTH*WORD-bit operand to the leading-zero counter, MSB byte first, one byte per cycle.
// Latency: first byte registered one cycle after the accept edge; next operand is accepted only after LZC_DONE (or timeout) plus one gap cycle.
module lzc_byte_feeder #(
    parameter int WIDTH   = 8,
    parameter int WORD    = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [WIDTH*WORD-1:0] in_data_i,
    input  logic                  in_mode_i,
    input  logic                  lzc_done_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  ivalid_o,
    output logic                  mode_o,
    output logic                  busy_o,
    output logic                  err_o
);
    localparam int OPW = WIDTH * WORD;
    localparam int CW  = $clog2(WORD) + 1;
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_GAP} state_t;

    state_t           state_q, state_d;
    logic [OPW-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    tmr_q, tmr_d, tmr_inc;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ivalid_q, ivalid_d;
    logic             mode_q, mode_d;
    logic             err_q, err_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            tmr_q    <= '0;
            data_q   <= '0;
            ivalid_q <= 1'b0;
            mode_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            data_q   <= data_d;
            ivalid_q <= ivalid_d;
            mode_q   <= mode_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        tmr_d    = tmr_q;
        data_d   = '0;
        ivalid_d = 1'b0;
        mode_d   = mode_q;
        err_d    = 1'b0;
        tmr_inc  = (tmr_q == TW'(TIMEOUT)) ? tmr_q : tmr_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                // Byte 0 is loaded straight into the output register so it appears on the next cycle.
                if (in_valid_i) begin
                    data_d   = in_data_i[OPW-1 -: WIDTH];
                    ivalid_d = 1'b1;
                    shreg_d  = in_data_i << WIDTH;
                    cnt_d    = CW'(1);
                    mode_d   = in_mode_i;
                    state_d  = S_SEND;
                end
            end
            S_SEND: begin
                // cnt_q counts bytes already driven, including the one visible this cycle.
                if (lzc_done_i) begin
                    state_d = S_GAP;
                end else if (cnt_q == CW'(WORD)) begin
                    tmr_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    data_d   = shreg_q[OPW-1 -: WIDTH];
                    ivalid_d = 1'b1;
                    shreg_d  = shreg_q << WIDTH;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (lzc_done_i) begin
                    state_d = S_GAP;
                end else begin
                    tmr_d = tmr_inc;
                    if (tmr_inc == TW'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready_o = (state_q == S_IDLE);
    assign busy_o     = (state_q != S_IDLE);
    assign data_o     = data_q;
    assign ivalid_o   = ivalid_q;
    assign mode_o     = mode_q;
    assign err_o      = err_q;
endmodule

// File: tb/tb_lzc_byte_feeder.sv
// Randomized bench for lzc_byte_feeder: expected byte streams and cycle positions come from the operand arithmetic and the handshake timing rules.
module tb_lzc_byte_feeder;
    localparam int WIDTH   = 8;
    localparam int WORD    = 16;
    localparam int TIMEOUT = 64;
    localparam int OPW     = WIDTH * WORD;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [OPW-1:0]   in_data_i;
    logic             in_mode_i;
    logic             lzc_done_i;
    logic [WIDTH-1:0] data_o;
    logic             ivalid_o;
    logic             mode_o;
    logic             busy_o;
    logic             err_o;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] obs_q[$];
    int r_ready_cyc, r_iv_cnt, r_err_cnt, r_err_cyc;
    bit r_mode_bad, r_hs_ok;

    lzc_byte_feeder #(.WIDTH(WIDTH), .WORD(WORD), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_data_i(in_data_i), .in_mode_i(in_mode_i), .lzc_done_i(lzc_done_i),
        .data_o(data_o), .ivalid_o(ivalid_o), .mode_o(mode_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [OPW-1:0] rand_op();
        logic [OPW-1:0] v;
        v = {$urandom, $urandom, $urandom, $urandom};
        return v;
    endfunction

    // Byte i of an operand, counting from the most significant end.
    function automatic logic [WIDTH-1:0] exp_byte(input logic [OPW-1:0] op, input int i);
        logic [OPW-1:0] s;
        s = op >> (WIDTH * (WORD - 1 - i));
        return s[WIDTH-1:0];
    endfunction

    // Drives one operand from IDLE and records what comes out until IN_READY returns.
    // done_byte: index of the byte during which LZC_DONE is raised (-1: not in SEND).
    // wait_done: WAIT cycle index at which LZC_DONE is raised (-1: never).
    task automatic run_op(input logic [OPW-1:0] op, input logic md, input int done_byte,
                          input int wait_done, input bit hold_done);
        int cyc, waitc;
        bit done_sent;
        obs_q.delete();
        r_ready_cyc = -1; r_iv_cnt = 0; r_err_cnt = 0; r_err_cyc = -1; r_mode_bad = 0;
        r_hs_ok = in_ready_o;
        in_valid_i = 1'b1; in_data_i = op; in_mode_i = md;
        @(negedge clk);
        in_valid_i = 1'b0; in_data_i = rand_op(); in_mode_i = ~md;
        cyc = 1; waitc = 0; done_sent = 0;
        while (cyc < 300) begin
            lzc_done_i = 1'b0;
            if (in_ready_o) begin
                r_ready_cyc = cyc;
                break;
            end
            if (mode_o !== md) r_mode_bad = 1;
            if (err_o) begin
                r_err_cnt++;
                r_err_cyc = cyc;
            end
            if (ivalid_o) begin
                obs_q.push_back(data_o);
                r_iv_cnt++;
                if (!done_sent && done_byte == obs_q.size() - 1) begin
                    lzc_done_i = 1'b1;
                    done_sent  = 1;
                end
            end else if (!done_sent) begin
                if (wait_done == waitc) begin
                    lzc_done_i = 1'b1;
                    done_sent  = 1;
                end
                waitc++;
            end else if (hold_done) begin
                lzc_done_i = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        lzc_done_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid_i = 1'b0; in_data_i = '0; in_mode_i = 1'b0; lzc_done_i = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({data_o, ivalid_o, mode_o, err_o, busy_o, in_ready_o} !== {8'h00, 5'b00001}) begin
            bad++;
            $display("FAIL reset_values got data=%h iv=%b mode=%b err=%b busy=%b rdy=%b expected 00 0 0 0 0 1",
                     data_o, ivalid_o, mode_o, err_o, busy_o, in_ready_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        lzc_done_i = 1'b1;
        @(negedge clk);
        lzc_done_i = 1'b0;
        total++;
        if ({busy_o, in_ready_o, ivalid_o, err_o} !== 4'b0100) begin
            bad++;
            $display("FAIL done_in_idle got busy=%b rdy=%b iv=%b err=%b expected 0 1 0 0",
                     busy_o, in_ready_o, ivalid_o, err_o);
        end
    endtask

    task automatic check_stream(input string name, input logic [OPW-1:0] op, input int nbytes,
                                input int ready_cyc, input int errs);
        bit ok;
        ok = (obs_q.size() == nbytes);
        for (int i = 0; i < obs_q.size() && ok; i++)
            if (obs_q[i] !== exp_byte(op, i)) ok = 0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_bytes got %0d bytes (first %h) expected %0d bytes (first %h)",
                     name, obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'h00, nbytes, exp_byte(op, 0));
        end
        total++;
        if (r_iv_cnt != nbytes || r_ready_cyc != ready_cyc || !r_hs_ok) begin
            bad++;
            $display("FAIL %s_timing got ivalid_cycles=%0d ready_cyc=%0d hs_ready=%0d expected %0d %0d 1",
                     name, r_iv_cnt, r_ready_cyc, r_hs_ok, nbytes, ready_cyc);
        end
        total++;
        if (r_err_cnt != errs || r_mode_bad) begin
            bad++;
            $display("FAIL %s_err_mode got err_pulses=%0d mode_bad=%0d expected %0d 0",
                     name, r_err_cnt, r_mode_bad, errs);
        end
    endtask

    task automatic test_full_word();
        logic [OPW-1:0] op;
        int w;
        op = 128'h1;
        run_op(op, 1'b0, -1, 0, 1'b0);
        check_stream("full_word_one", op, WORD, WORD + 3, 0);
        for (int k = 0; k < 4; k++) begin
            op = rand_op();
            w = $urandom_range(0, 5);
            run_op(op, 1'b0, -1, w, 1'b1);
            check_stream("full_word_rand", op, WORD, WORD + 3 + w, 0);
        end
    endtask

    task automatic test_early_stop();
        logic [OPW-1:0] op;
        int k;
        op = rand_op();
        op[OPW-1 -: 24] = 24'h000080;
        run_op(op, 1'b1, 2, -1, 1'b1);
        check_stream("early_stop_b2", op, 3, 5, 0);
        for (int n = 0; n < 4; n++) begin
            op = rand_op();
            k = $urandom_range(0, WORD - 2);
            run_op(op, 1'b1, k, -1, 1'b0);
            check_stream("early_stop_rand", op, k + 1, k + 3, 0);
        end
    endtask

    task automatic test_last_byte();
        logic [OPW-1:0] op;
        op = rand_op();
        run_op(op, 1'b1, WORD - 1, 0, 1'b0);
        check_stream("done_last_byte", op, WORD, WORD + 2, 0);
    endtask

    task automatic test_timeout();
        logic [OPW-1:0] op;
        op = rand_op();
        run_op(op, 1'b0, -1, -1, 1'b0);
        check_stream("timeout", op, WORD, WORD + TIMEOUT + 2, 1);
        total++;
        if (r_err_cyc != WORD + TIMEOUT + 1) begin
            bad++;
            $display("FAIL timeout_err_cycle got %0d expected %0d", r_err_cyc, WORD + TIMEOUT + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic [OPW-1:0] a, b;
        int cyc, hs2, first_b;
        bit took2, overlap, d1, ok;
        a = rand_op(); b = rand_op();
        obs_q.delete();
        hs2 = -1; first_b = -1; took2 = 0; overlap = 0; d1 = 0;
        in_valid_i = 1'b1; in_data_i = a; in_mode_i = 1'b0;
        @(negedge clk);
        in_data_i = b;
        cyc = 1;
        while (cyc < 200) begin
            lzc_done_i = 1'b0;
            if (took2 && in_valid_i) begin
                in_valid_i = 1'b0;
                in_data_i  = rand_op();
            end
            if (in_ready_o) begin
                if (took2) break;
                hs2 = cyc;
                took2 = 1;
            end
            if (ivalid_o) begin
                if (in_ready_o) overlap = 1;
                obs_q.push_back(data_o);
                if (obs_q.size() == WORD + 1) first_b = cyc;
            end else if (busy_o && !d1 && obs_q.size() == WORD) begin
                lzc_done_i = 1'b1;
                d1 = 1;
            end else if (busy_o && obs_q.size() == 2 * WORD && !in_ready_o) begin
                lzc_done_i = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        lzc_done_i = 1'b0;
        in_valid_i = 1'b0;
        ok = (obs_q.size() == 2 * WORD);
        for (int i = 0; i < obs_q.size() && ok; i++)
            if (obs_q[i] !== ((i < WORD) ? exp_byte(a, i) : exp_byte(b, i - WORD))) ok = 0;
        total++;
        if (!ok || overlap) begin
            bad++;
            $display("FAIL b2b_bytes got %0d bytes overlap=%0d expected %0d bytes in order, no overlap",
                     obs_q.size(), overlap, 2 * WORD);
        end
        total++;
        if (hs2 != WORD + 3 || first_b != WORD + 4) begin
            bad++;
            $display("FAIL b2b_timing got second_accept=%0d first_b_byte=%0d expected %0d %0d",
                     hs2, first_b, WORD + 3, WORD + 4);
        end
    endtask

    task automatic test_reset_mid();
        logic [OPW-1:0] op;
        op = rand_op();
        in_valid_i = 1'b1; in_data_i = op; in_mode_i = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (!ivalid_o || data_o !== exp_byte(op, 5)) begin
            bad++;
            $display("FAIL mid_byte5 got iv=%b data=%h expected 1 %h", ivalid_o, data_o, exp_byte(op, 5));
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({data_o, ivalid_o, mode_o, err_o, busy_o, in_ready_o} !== {8'h00, 5'b00001}) begin
            bad++;
            $display("FAIL mid_reset_values got data=%h iv=%b mode=%b err=%b busy=%b rdy=%b expected 00 0 0 0 0 1",
                     data_o, ivalid_o, mode_o, err_o, busy_o, in_ready_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op = rand_op();
        run_op(op, 1'b0, WORD - 1, -1, 1'b0);
        check_stream("after_reset", op, WORD, WORD + 2, 0);
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_early_stop();
        test_last_byte();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
